griffin_host_ctrl: RTL

Host-side sequencer that drives the load/compute/read interface of griffin_top and exposes a simple valid/ready word stream to the rest of the system. It accepts STATE_SIZE input words, streams them into the core with wr, pulses enable, and waits for done. It then asserts rd, captures STATE_SIZE output words into a local buffer, and drains them downstream. It sits between the system interconnect / hash-scheduler and one griffin_top instance.

---
 rtl/griffin_host_pkg.sv | 16 +
 rtl/griffin_host_obuf.sv | 60 ++++++
 rtl/griffin_host_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/griffin_host_pkg.sv
// rtl/griffin_host_pkg.sv - shared types and constants for the griffin host sequencer
// Purpose: sequencer state encoding, counter width helper and default sizes.
// Ports: none (package).
package griffin_host_pkg;

  localparam int GRIFFIN_N_BITS     = 254;
  localparam int GRIFFIN_STATE_SIZE = 3;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, READ, DRAIN} state_t;

  // Counters must be able to hold the value n itself, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/griffin_host_obuf.sv
// rtl/griffin_host_obuf.sv - result word buffer between core read-out and downstream drain
// Purpose: STATE_SIZE-deep register buffer with a capture pointer and a drain pointer.
// Ports:
//   clk, reset      clock, synchronous active-high reset (pointers only)
//   clr             zero every entry and rewind both pointers
//   wr_en, wr_data  capture one word at wr_ptr
//   rd_adv          advance the drain pointer
//   wr_ptr          number of words captured since the last clr
//   rd_data         entry at the drain pointer
//   rd_last         drain pointer is on the final entry
module griffin_host_obuf
  import griffin_host_pkg::*;
#(
  parameter int N_BITS     = GRIFFIN_N_BITS,
  parameter int STATE_SIZE = GRIFFIN_STATE_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [N_BITS-1:0]                wr_data,
  input  logic                             rd_adv,
  output logic [cnt_width(STATE_SIZE)-1:0] wr_ptr,
  output logic [N_BITS-1:0]                rd_data,
  output logic                             rd_last
);

  localparam int CW = cnt_width(STATE_SIZE);

  logic [N_BITS-1:0] mem [STATE_SIZE];
  logic [CW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + CW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Clearing up front means entries never reached by an early rd_done drain as zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STATE_SIZE; i++) begin
      if (clr)                               mem[i] <= '0;
      else if (wr_en && wr_ptr == CW'(i))    mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < STATE_SIZE; i++) begin
      if (rd_ptr == CW'(i)) rd_data = mem[i];
    end
  end

  assign rd_last = (rd_ptr == CW'(STATE_SIZE - 1));

endmodule

// File: rtl/griffin_host_ctrl.sv
// rtl/griffin_host_ctrl.sv - host sequencer feeding one griffin_top permutation core
// Purpose: load STATE_SIZE words into the core, kick it, read the result back, and
//          stream the result downstream. Optional build macro: GRIFFIN_HOST_PERF_EN
//          adds perf_cycles (KICK+WAIT cycle count of the last permutation).
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   s_valid, s_ready, s_data       upstream input word stream
//   m_valid, m_ready, m_data, m_last  downstream result word stream
//   core_wr, core_enable, core_rd, core_inState    to griffin_top
//   core_outState, core_done, core_rd_done         from griffin_top
//   busy                           high outside IDLE
//   perf_cycles                    (GRIFFIN_HOST_PERF_EN only)
module griffin_host_ctrl
  import griffin_host_pkg::*;
#(
  parameter int N_BITS        = GRIFFIN_N_BITS,
  parameter int STATE_SIZE    = GRIFFIN_STATE_SIZE,
  parameter int ENABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N_BITS-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_BITS-1:0] m_data,
  output logic              m_last,
  output logic              core_wr,
  output logic              core_enable,
  output logic              core_rd,
  output logic [N_BITS-1:0] core_inState,
  input  logic [N_BITS-1:0] core_outState,
  input  logic              core_done,
  input  logic              core_rd_done,
  output logic              busy
`ifdef GRIFFIN_HOST_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int CW = cnt_width(STATE_SIZE);
  localparam int EW = cnt_width(ENABLE_CYCLES);

  state_t            state, state_nx;
  logic [CW-1:0]     wcnt;
  logic [EW-1:0]     ecnt;
  logic              rd_started;
  logic [N_BITS-1:0] in_state_q;
  logic              cap_en;
  logic [CW-1:0]     ob_wr_ptr;
  logic [N_BITS-1:0] ob_rd_data;
  logic              ob_last;

  // The core needs one cycle after rd rises before outState is meaningful.
  assign cap_en       = (state == READ) && rd_started;
  assign core_inState = in_state_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s_valid)                    state_nx = LOAD;
      LOAD:    if (wcnt == CW'(STATE_SIZE))    state_nx = KICK;
      KICK:    if (ecnt == EW'(ENABLE_CYCLES - 1)) state_nx = WAIT;
      WAIT:    if (core_done)                  state_nx = READ;
      READ:    if (cap_en && (core_rd_done || ob_wr_ptr == CW'(STATE_SIZE - 1)))
                 state_nx = DRAIN;
      DRAIN:   if (m_ready && ob_last)         state_nx = IDLE;
      default:                                 state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_ready     = 1'b0;
    core_wr     = 1'b0;
    core_enable = 1'b0;
    core_rd     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;
    busy        = (state != IDLE);
    case (state)
      IDLE:  s_ready = 1'b1;
      LOAD: begin
        core_wr = 1'b1;
        s_ready = (wcnt < CW'(STATE_SIZE));
      end
      KICK:  core_enable = 1'b1;
      READ:  core_rd = 1'b1;
      DRAIN: begin
        m_valid = 1'b1;
        m_data  = ob_rd_data;
        m_last  = ob_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt       <= '0;
      ecnt       <= '0;
      rd_started <= 1'b0;
      in_state_q <= '0;
    end else begin
      if (s_valid && s_ready) begin
        in_state_q <= s_data;
        wcnt       <= (state == IDLE) ? CW'(1) : wcnt + CW'(1);
      end
      ecnt       <= (state == KICK) ? ecnt + EW'(1) : '0;
      rd_started <= (state == READ);
    end
  end

  griffin_host_obuf #(
    .N_BITS     (N_BITS),
    .STATE_SIZE (STATE_SIZE)
  ) u_obuf (
    .clk     (clk),
    .reset   (reset),
    .clr     ((state == READ) && !rd_started),
    .wr_en   (cap_en),
    .wr_data (core_outState),
    .rd_adv  ((state == DRAIN) && m_ready),
    .wr_ptr  (ob_wr_ptr),
    .rd_data (ob_rd_data),
    .rd_last (ob_last)
  );

`ifdef GRIFFIN_HOST_PERF_EN
  logic [31:0] perf_cnt;

  // The done cycle itself is counted, so the snapshot takes perf_cnt+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else if (state == LOAD && state_nx == KICK) begin
      perf_cnt <= '0;
    end else if (state == KICK || state == WAIT) begin
      perf_cnt <= perf_cnt + 32'd1;
      if (state == WAIT && core_done) perf_cycles <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule
